// File: rtl/q_ingress_arb.sv
// Packet-aware round-robin arbiter for the q ingress port: locks the grant from sop to eop,
// drops orphan beats in IDLE and truncates packets that run past MAX_BEATS.
module q_ingress_arb #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [N-1:0]         i_req_vld,
  input  logic [N-1:0]         i_req_sop,
  input  logic [N-1:0]         i_req_eop,
  output logic [N-1:0]         o_req_accept,
  input  logic                 i_stall,
  output logic                 o_ingress_vld_r,
  output logic                 o_ingress_sop_r,
  output logic                 o_ingress_eop_r,
  output logic [$clog2(N)-1:0] o_ingress_sel_r,
  output logic                 o_orphan_r,
  output logic                 o_trunc_r,
  output logic [1:0]           o_state_dbg
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  // Handshake: a requester beat transfers in the cycle where i_req_vld[k] & o_req_accept[k];
  // the requester holds vld/sop/eop stable until then. i_stall only gates forwarded beats.

  state_e         state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [SW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           vld_q, vld_d;
  logic           sop_q, sop_d;
  logic           eop_q, eop_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           orph_q, orph_d;
  logic           trunc_q, trunc_d;
  logic [N-1:0]   accept;

  logic           sop_found, orph_found;
  logic [SW-1:0]  sop_idx, orph_idx;
  int             scan_j;

  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] k);
    return (int'(k) == N - 1) ? '0 : k + SW'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    vld_d      = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    sel_d      = '0;
    orph_d     = 1'b0;
    trunc_d    = 1'b0;
    accept     = '0;
    sop_found  = 1'b0;
    orph_found = 1'b0;
    sop_idx    = '0;
    orph_idx   = '0;
    scan_j     = 0;

    // Rotating scan from ptr: first sop candidate and first orphan candidate.
    for (int i = 0; i < N; i++) begin
      scan_j = (int'(ptr_q) + i) % N;
      if (!sop_found && i_req_vld[scan_j] && i_req_sop[scan_j]) begin
        sop_found = 1'b1;
        sop_idx   = SW'(scan_j);
      end
      if (!orph_found && i_req_vld[scan_j] && !i_req_sop[scan_j]) begin
        orph_found = 1'b1;
        orph_idx   = SW'(scan_j);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sop_found) begin
          if (!i_stall) begin
            accept[sop_idx] = 1'b1;
            vld_d = 1'b1;
            sop_d = 1'b1;
            eop_d = i_req_eop[sop_idx];
            sel_d = sop_idx;
            if (i_req_eop[sop_idx]) begin
              ptr_d = next_idx(sop_idx);
            end else begin
              state_d = S_LOCKED;
              owner_d = sop_idx;
              cnt_d   = CW'(1);
            end
          end
        end else if (orph_found) begin
          accept[orph_idx] = 1'b1;
          orph_d = 1'b1;
        end
      end
      S_LOCKED: begin
        if (i_req_vld[owner_q] && !i_stall) begin
          accept[owner_q] = 1'b1;
          vld_d = 1'b1;
          sel_d = owner_q;
          cnt_d = cnt_q + CW'(1);
          if (i_req_eop[owner_q]) begin
            eop_d   = 1'b1;
            state_d = S_IDLE;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == CW'(MAX_BEATS)) begin
            // Runaway packet: close it downstream and swallow the rest of it.
            eop_d   = 1'b1;
            trunc_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (i_req_vld[owner_q]) begin
          accept[owner_q] = 1'b1;
          if (i_req_eop[owner_q]) begin
            state_d = S_IDLE;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arst) accept = '0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      sel_q   <= '0;
      orph_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      sel_q   <= sel_d;
      orph_q  <= orph_d;
      trunc_q <= trunc_d;
    end
  end

  assign o_req_accept    = accept;
  assign o_ingress_vld_r = vld_q;
  assign o_ingress_sop_r = sop_q;
  assign o_ingress_eop_r = eop_q;
  assign o_ingress_sel_r = sel_q;
  assign o_orphan_r      = orph_q;
  assign o_trunc_r       = trunc_q;
  assign o_state_dbg     = state_q;

endmodule

// File: tb/tb_q_ingress_arb.sv
// Directed table of per-cycle vectors for q_ingress_arb (N=4, MAX_BEATS=4), plus a
// hand-written reset-mid-packet sequence.
module tb_q_ingress_arb;

  logic       clk = 1'b0;
  logic       arst;
  logic [3:0] req_vld, req_sop, req_eop, req_accept;
  logic       stall;
  logic       ing_vld, ing_sop, ing_eop, orphan, trunc;
  logic [1:0] ing_sel, state_dbg;

  int checks = 0;
  int errors = 0;

  q_ingress_arb #(.N(4), .MAX_BEATS(4)) dut (
    .clk             (clk),
    .arst            (arst),
    .i_req_vld       (req_vld),
    .i_req_sop       (req_sop),
    .i_req_eop       (req_eop),
    .o_req_accept    (req_accept),
    .i_stall         (stall),
    .o_ingress_vld_r (ing_vld),
    .o_ingress_sop_r (ing_sop),
    .o_ingress_eop_r (ing_eop),
    .o_ingress_sel_r (ing_sel),
    .o_orphan_r      (orphan),
    .o_trunc_r       (trunc),
    .o_state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld, sop, eop;
    logic       stall;
    logic [3:0] acc;
    logic       ov, os, oe;
    logic [1:0] sel;
    logic       orph, tr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] v, s, e, input logic st, input logic [3:0] a,
                     input logic ov, os, oe, input logic [1:0] sel, input logic orph, tr);
    vec_t r;
    r.vld = v; r.sop = s; r.eop = e; r.stall = st; r.acc = a;
    r.ov = ov; r.os = os; r.oe = oe; r.sel = sel; r.orph = orph; r.tr = tr;
    vq.push_back(r);
  endtask

  task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual %0h required %0h", nm, row, act, exp);
    end
  endtask

  task automatic chk_outs(input int row, input logic ov, os, oe, input logic [1:0] sel,
                          input logic orph, tr);
    chk("vld_r",    row, {7'd0, ing_vld}, {7'd0, ov});
    chk("sop_r",    row, {7'd0, ing_sop}, {7'd0, os});
    chk("eop_r",    row, {7'd0, ing_eop}, {7'd0, oe});
    chk("sel_r",    row, {6'd0, ing_sel}, {6'd0, sel});
    chk("orphan_r", row, {7'd0, orphan},  {7'd0, orph});
    chk("trunc_r",  row, {7'd0, trunc},   {7'd0, tr});
  endtask

  // Drive at negedge, check the combinational accept, then check the registered result.
  task automatic apply(input vec_t r, input int row);
    @(negedge clk);
    req_vld = r.vld; req_sop = r.sop; req_eop = r.eop; stall = r.stall;
    #1;
    chk("accept", row, {4'd0, req_accept}, {4'd0, r.acc});
    @(posedge clk);
    #1;
    chk_outs(row, r.ov, r.os, r.oe, r.sel, r.orph, r.tr);
  endtask

  initial begin
    // Two 3-beat / 2-beat packets contend; req2 waits for req0's eop.
    add(4'b0101, 4'b0101, 4'b0000, 0, 4'b0001, 1, 1, 0, 2'd0, 0, 0);
    add(4'b0101, 4'b0100, 4'b0000, 0, 4'b0001, 1, 0, 0, 2'd0, 0, 0);
    add(4'b0101, 4'b0100, 4'b0001, 0, 4'b0001, 1, 0, 1, 2'd0, 0, 0);
    add(4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 0, 2'd2, 0, 0);
    add(4'b0100, 4'b0000, 4'b0100, 0, 4'b0100, 1, 0, 1, 2'd2, 0, 0);
    // Single-beat req3 brings ptr back to 0, then continuous single-beat packets rotate.
    add(4'b1000, 4'b1000, 4'b1000, 0, 4'b1000, 1, 1, 1, 2'd3, 0, 0);
    for (int k = 0; k < 5; k++)
      add(4'b1111, 4'b1111, 4'b1111, 0, 4'(1 << (k % 4)), 1, 1, 1, 2'(k % 4), 0, 0);
    // req1 4-beat (exactly MAX_BEATS) with a 2-cycle stall; req0 waits with a sop.
    add(4'b0011, 4'b0011, 4'b0000, 0, 4'b0010, 1, 1, 0, 2'd1, 0, 0);
    add(4'b0011, 4'b0001, 4'b0000, 0, 4'b0010, 1, 0, 0, 2'd1, 0, 0);
    add(4'b0011, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 2'd0, 0, 0);
    add(4'b0011, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 2'd0, 0, 0);
    add(4'b0011, 4'b0011, 4'b0000, 0, 4'b0010, 1, 0, 0, 2'd1, 0, 0);
    add(4'b0011, 4'b0001, 4'b0010, 0, 4'b0010, 1, 0, 1, 2'd1, 0, 0);
    add(4'b0001, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 1, 2'd0, 0, 0);
    // req3 6-beat packet: truncated at beat 4, beats 5-6 drained (beat 5 under stall).
    add(4'b1000, 4'b1000, 4'b0000, 0, 4'b1000, 1, 1, 0, 2'd3, 0, 0);
    add(4'b1000, 4'b0000, 4'b0000, 0, 4'b1000, 1, 0, 0, 2'd3, 0, 0);
    add(4'b1000, 4'b0000, 4'b0000, 0, 4'b1000, 1, 0, 0, 2'd3, 0, 0);
    add(4'b1000, 4'b0000, 4'b0000, 0, 4'b1000, 1, 0, 1, 2'd3, 0, 1);
    add(4'b1010, 4'b0010, 4'b0000, 1, 4'b1000, 0, 0, 0, 2'd0, 0, 0);
    add(4'b1010, 4'b0010, 4'b1000, 0, 4'b1000, 0, 0, 0, 2'd0, 0, 0);
    add(4'b0011, 4'b0011, 4'b0011, 0, 4'b0001, 1, 1, 1, 2'd0, 0, 0);
    add(4'b0010, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 2'd1, 0, 0);
    // Orphans: a pending sop blocks orphan drops even under stall; lone orphan drops while stalled.
    add(4'b0110, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 0, 2'd0, 0, 0);
    add(4'b0110, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 2'd1, 0, 0);
    add(4'b0100, 4'b0000, 4'b0000, 1, 4'b0100, 0, 0, 0, 2'd0, 1, 0);

    // Reset state, with requests present so accept gating is visible.
    arst = 1'b1; req_vld = 4'b1111; req_sop = 4'b1111; req_eop = 4'b0000; stall = 1'b0;
    #2;
    chk("rst_accept", -1, {4'd0, req_accept}, 8'd0);
    @(posedge clk);
    #1;
    chk("rst_accept", -1, {4'd0, req_accept}, 8'd0);
    chk_outs(-1, 0, 0, 0, 2'd0, 0, 0);
    arst = 1'b0;

    for (int r = 0; r < vq.size(); r++) apply(vq[r], r);

    // Reset mid-packet: req0 3-beat packet, arst asserted during beat 2.
    begin
      vec_t b1;
      b1 = '{vld:4'b0001, sop:4'b0001, eop:4'b0000, stall:0, acc:4'b0001,
             ov:1, os:1, oe:0, sel:2'd0, orph:0, tr:0};
      apply(b1, 100);
      @(negedge clk);
      req_vld = 4'b0001; req_sop = 4'b0000; req_eop = 4'b0000; stall = 1'b0;
      #1;
      chk("b2_accept", 101, {4'd0, req_accept}, 8'h01);
      #1 arst = 1'b1;
      #1;
      chk("mid_rst_accept", 101, {4'd0, req_accept}, 8'h00);
      chk_outs(101, 0, 0, 0, 2'd0, 0, 0);
      @(posedge clk);
      #1;
      chk_outs(102, 0, 0, 0, 2'd0, 0, 0);
      arst = 1'b0;
    end
    // Abandoned beats 2 and 3 drop as orphans; req1's packet then wins from ptr=0.
    vq.delete();
    add(4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0, 2'd0, 1, 0);
    add(4'b0001, 4'b0000, 4'b0001, 0, 4'b0001, 0, 0, 0, 2'd0, 1, 0);
    add(4'b0010, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 2'd1, 0, 0);
    add(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0, 0, 0);
    for (int r = 0; r < vq.size(); r++) apply(vq[r], 200 + r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_ingress_arb.md
Name: q_ingress_arb

Overview:
Packet-aware round-robin arbiter sharing the single ingress port of the q queue among N requesters. Grant is locked from sop to eop, so packets are never interleaved on the queue ingress. Sits directly in front of q and drives its i_ingress_vld/sop/eop. Also sequences protocol recovery: it drops orphan beats and truncates runaway packets.

Parameters:
N, 4, number of requesters (>=2)
MAX_BEATS, 16, max beats per packet before forced truncation (>=2)

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
i_req_vld  in  N  requester beat valid, one bit per requester
i_req_sop  in  N  requester start-of-packet
i_req_eop  in  N  requester end-of-packet
o_req_accept  out  N  beat accepted this cycle (combinational, one-hot or zero)
i_stall  in  1  queue cannot take a beat this cycle
o_ingress_vld_r  out  1  forwarded beat valid (to q i_ingress_vld)
o_ingress_sop_r  out  1  forwarded sop
o_ingress_eop_r  out  1  forwarded eop (may be forced on truncation)
o_ingress_sel_r  out  $clog2(N)  index of the requester owning the forwarded beat
o_orphan_r  out  1  one-cycle pulse: a non-sop beat was dropped in IDLE
o_trunc_r  out  1  one-cycle pulse: packet truncated at MAX_BEATS

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, ptr=0, owner=0, beat_cnt=0. All o_* registered outputs are 0. o_req_accept is 0 while arst is high.
- A requester beat transfers when i_req_vld[k] & o_req_accept[k]. A requester holds vld/sop/eop stable until the beat is accepted.
- Forwarded beats appear on o_ingress_*_r exactly 1 cycle after acceptance. o_ingress_vld_r=0 in any cycle with no forwarded acceptance.
- State IDLE:
  - Candidates are the requesters with vld&sop. The winner is the first candidate at or after ptr, scanning upward modulo N.
  - If i_stall=0, the winner is accepted and forwarded with sop=1.
  - If the winner's eop=1 (single-beat packet): stay IDLE, ptr=winner+1 mod N.
  - Otherwise: go to LOCKED, owner=winner, beat_cnt=1.
  - If i_stall=1: no sop beat is accepted and ptr is unchanged.
  - Orphan beats (vld & ~sop) are only considered when no sop candidate exists. The lowest such index at or after ptr is accepted even when stalled, is not forwarded, and o_orphan_r pulses.
- State LOCKED:
  - Only the owner can be accepted, and only when i_stall=0. All other requesters are held off.
  - Each accepted beat is forwarded and beat_cnt increments.
  - A sop seen mid-packet is forwarded with sop_r=0 (sop is ignored while locked).
  - Owner eop: forward it, go to IDLE, ptr=owner+1 mod N.
  - If the accepted beat is beat number MAX_BEATS and eop=0: forward it with eop_r forced to 1, pulse o_trunc_r with the same timing as the beat, go to DRAIN.
- State DRAIN:
  - Owner beats are accepted regardless of i_stall and are not forwarded.
  - On the owner's eop beat: go to IDLE, ptr=owner+1 mod N.
  - Other requesters are held off.
- Fairness: a requester that has a pending sop is granted within N-1 packets.
- beat_cnt width is $clog2(MAX_BEATS+1). It never wraps because truncation occurs at MAX_BEATS.
- A packet of exactly MAX_BEATS beats with eop on the last beat completes normally: no truncation and no DRAIN.
- Reset mid-packet abandons the packet. The source's remaining beats then arrive without sop and are dropped as orphans.
- Simultaneous events: at most one accept per cycle. In IDLE a sop candidate always takes priority over an orphan.

Test Plan:
1. N=4, ptr=0: req0 (3-beat) and req2 (2-beat) assert sop together -> sel_r=0,0,0 with sop_r on beat 1 and eop_r on beat 3, then sel_r=2,2; req2's accept stays 0 during req0's packet.
2. All 4 requesters present single-beat sop&eop packets continuously -> sel_r sequence 0,1,2,3,0 on consecutive cycles; vld_r=1 every cycle.
3. req1 4-beat packet with i_stall=1 for 2 cycles after beat 2 -> accept[1]=0 and vld_r=0 during the stall; 4 beats forwarded in order, eop_r on the 4th; no other requester is granted mid-packet.
4. MAX_BEATS=4, req3 sends a 6-beat packet -> 4 beats forwarded, 4th has eop_r=1 and o_trunc_r=1; beats 5-6 accepted and dropped; next packet granted after beat 6 with ptr=0.
5. In IDLE, req2 presents vld=1 sop=0 while i_stall=1 and no sop is pending -> accept[2]=1, vld_r=0, o_orphan_r=1 the next cycle.
6. Assert arst during beat 2 of a 3-beat req0 packet -> all outputs 0 immediately; after release req0's beat 3 is dropped as an orphan and a req1 sop packet is granted normally.
